// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Definitions shared by the fetch stage and the decode stage:
//   fetch FSM state encoding, the bubble instruction word, RV32I major
//   opcodes (also used by decode / immediate generation) and a small
//   address-alignment helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    // addi x0,x0,0 -- the bubble shown to decode when IF/ID is empty
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Instruction-memory request/response bus.
//   imem_req   : fetch request (driven by fetch unit)
//   imem_addr  : fetch address, stable while a request is pending
//   imem_ready : memory returns data this cycle
//   imem_rdata : instruction word, valid when imem_req && imem_ready
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register feeding decode.
//   clk, rst_n      : clock, synchronous active-low reset
//   i_flush         : invalidate (instruction -> NOP, pc kept), wins over load
//   i_load          : capture i_instr / i_pc as a valid instruction
//   o_instr/o_pc    : registered instruction and its PC
//   o_valid         : register holds a real instruction
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid
);
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            // PC is left alone so decode still sees where the bubble sits
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage: PC, single-outstanding instruction-memory
//   handshake, one-entry hold buffer for decode stalls, redirect with
//   discard of a stale in-flight fetch, and the IF/ID register.
//   clk, rst_n     : clock, synchronous active-low reset
//   stall          : decode cannot accept, IF/ID holds
//   flush          : redirect to branch_target (low 2 bits ignored)
//   imem           : instruction-memory bus (master side)
//   instrucao      : IF/ID instruction (NOP when invalid)
//   pc_out         : PC of instrucao
//   valid_out      : IF/ID holds a real instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        branch_target,
    fetch_unit_if.master       imem,
    output logic [31:0]        instrucao,
    output logic [31:0]        pc_out,
    output logic               valid_out
);
    import fetch_unit_pkg::*;

    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic         r_req, w_req_next;
    logic [31:0]  r_addr, w_addr_next;
    logic [31:0]  r_buf_instr, w_buf_instr_next;
    logic [31:0]  r_buf_addr, w_buf_addr_next;

    logic         w_xfer;
    logic [31:0]  w_target;
    logic [31:0]  w_addr_inc;
    logic [31:0]  w_buf_inc;
    logic         w_ifid_load;
    logic         w_ifid_flush;
    logic [31:0]  w_ifid_instr;
    logic [31:0]  w_ifid_pc;

    assign w_xfer     = r_req && imem.imem_ready;
    assign w_target   = word_align(branch_target);
    assign w_addr_inc = r_addr + 32'd4;      // wraps modulo 2^32
    assign w_buf_inc  = r_buf_addr + 32'd4;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_req_next       = r_req;
        w_addr_next      = r_addr;
        w_buf_instr_next = r_buf_instr;
        w_buf_addr_next  = r_buf_addr;
        w_ifid_load      = 1'b0;
        w_ifid_flush     = 1'b0;
        w_ifid_instr     = imem.imem_rdata;
        w_ifid_pc        = r_addr;

        if (flush) begin
            w_ifid_flush     = 1'b1;
            w_pc_next        = w_target;
            w_buf_instr_next = NOP_INSTR;
            w_buf_addr_next  = '0;
            if ((r_state == ST_FETCH || r_state == ST_DISCARD) && !w_xfer) begin
                // A request is still pending: its address must stay put,
                // so let it complete and throw the data away.
                w_state_next = ST_DISCARD;
            end else begin
                w_addr_next  = w_target;
                w_req_next   = 1'b1;
                w_state_next = ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_FETCH;
                    w_req_next   = 1'b1;
                    w_addr_next  = r_pc;
                end
                ST_FETCH: begin
                    if (w_xfer) begin
                        if (!stall) begin
                            // Issue the next fetch immediately: no bubble
                            w_ifid_load = 1'b1;
                            w_pc_next   = w_addr_inc;
                            w_addr_next = w_addr_inc;
                        end else begin
                            // Decode busy: park the word, stop fetching
                            w_buf_instr_next = imem.imem_rdata;
                            w_buf_addr_next  = r_addr;
                            w_req_next       = 1'b0;
                            w_state_next     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_ifid_load  = 1'b1;
                        w_ifid_instr = r_buf_instr;
                        w_ifid_pc    = r_buf_addr;
                        w_pc_next    = w_buf_inc;
                        w_addr_next  = w_buf_inc;
                        w_req_next   = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (w_xfer) begin
                        // Stale word dropped; pc already holds the redirect
                        w_addr_next  = r_pc;
                        w_state_next = ST_FETCH;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_addr      <= RESET_PC;
            r_buf_instr <= NOP_INSTR;
            r_buf_addr  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_req       <= w_req_next;
            r_addr      <= w_addr_next;
            r_buf_instr <= w_buf_instr_next;
            r_buf_addr  <= w_buf_addr_next;
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ifid_load),
        .i_flush (w_ifid_flush),
        .i_instr (w_ifid_instr),
        .i_pc    (w_ifid_pc),
        .o_instr (instrucao),
        .o_pc    (pc_out),
        .o_valid (valid_out)
    );
endmodule
